// File: rtl/commit_arbiter.sv
// ============================================================================
// Module   : commit_arbiter
// Purpose  : Shared regfile write port and scoreboard commit source fed by an
//            INTU hold register and a bursty load-return queue.
// Revision : 1.0
// ============================================================================
`default_nettype none

module commit_arbiter #(
  parameter int NUM_WARP_LOG    = 3,
  parameter int SIZE_REGFILE_BR = 5,
  parameter int SIZE_CORE       = 8,
  parameter int SIZE_DATA       = 32,
  parameter int LQ_DEPTH        = 4,
  parameter int LQ_HIWATER      = 3,
  parameter int STARVE_MAX      = 7
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           stall_i,
  input  logic                           intuValid_i,
  output logic                           intuReady_o,
  input  logic [NUM_WARP_LOG-1:0]        intuWarp_i,
  input  logic [SIZE_CORE-1:0]           intuMask_i,
  input  logic                           intuDestValid_i,
  input  logic [SIZE_REGFILE_BR-1:0]     intuDest_i,
  input  logic [SIZE_CORE*SIZE_DATA-1:0] intuData_i,
  input  logic                           ldValid_i,
  output logic                           ldReady_o,
  input  logic [NUM_WARP_LOG-1:0]        ldWarp_i,
  input  logic [SIZE_CORE-1:0]           ldMask_i,
  input  logic [SIZE_REGFILE_BR-1:0]     ldDest_i,
  input  logic [SIZE_CORE*SIZE_DATA-1:0] ldData_i,
  output logic                           wbValid_o,
  output logic [NUM_WARP_LOG-1:0]        wbWarp_o,
  output logic [SIZE_CORE-1:0]           wbMask_o,
  output logic [SIZE_REGFILE_BR-1:0]     wbDest_o,
  output logic [SIZE_CORE*SIZE_DATA-1:0] wbData_o,
  output logic                           intuCommit_o,
  output logic                           loadCommit_o
);

  localparam int c_PTR_W = $clog2(LQ_DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam int c_STV_W = $clog2(STARVE_MAX + 1);
  localparam int c_DAT_W = SIZE_CORE * SIZE_DATA;

  logic                       r_readyEn;
  logic [c_CNT_W-1:0]         r_count;
  logic [c_PTR_W-1:0]         r_wrPtr;
  logic [c_PTR_W-1:0]         r_rdPtr;
  logic [c_STV_W-1:0]         r_starve;

  logic [NUM_WARP_LOG-1:0]    r_qWarp [LQ_DEPTH];
  logic [SIZE_CORE-1:0]       r_qMask [LQ_DEPTH];
  logic [SIZE_REGFILE_BR-1:0] r_qDest [LQ_DEPTH];
  logic [c_DAT_W-1:0]         r_qData [LQ_DEPTH];

  logic                       r_held;
  logic [NUM_WARP_LOG-1:0]    r_hWarp;
  logic [SIZE_CORE-1:0]       r_hMask;
  logic                       r_hDv;
  logic [SIZE_REGFILE_BR-1:0] r_hDest;
  logic [c_DAT_W-1:0]         r_hData;

  logic w_qNotEmpty, w_forceLoad, w_grantLoad, w_grantIntu, w_intuWrite;
  logic w_push, w_intuLoad;
  logic                       w_nValid;
  logic [NUM_WARP_LOG-1:0]    w_nWarp;
  logic [SIZE_CORE-1:0]       w_nMask;
  logic [SIZE_REGFILE_BR-1:0] w_nDest;
  logic [c_DAT_W-1:0]         w_nData;

  // Arbitration: forced load (hiwater or starvation) beats a held INTU result.
  assign w_qNotEmpty = (r_count != '0);
  assign w_forceLoad = (r_count >= c_CNT_W'(LQ_HIWATER)) ||
                       (w_qNotEmpty && (r_starve == c_STV_W'(STARVE_MAX)));
  assign w_grantLoad = ~stall_i & (w_forceLoad | (~r_held & w_qNotEmpty));
  assign w_grantIntu = ~stall_i & r_held & ~w_forceLoad;
  assign w_intuWrite = w_grantIntu & r_hDv;

  assign ldReady_o   = r_readyEn & (r_count < c_CNT_W'(LQ_DEPTH));
  assign intuReady_o = r_readyEn & (~r_held | w_grantIntu);
  assign w_push      = ldValid_i & ldReady_o;
  assign w_intuLoad  = intuValid_i & intuReady_o;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_readyEn <= 1'b0;
      r_count   <= '0;
      r_wrPtr   <= '0;
      r_rdPtr   <= '0;
      r_starve  <= '0;
    end else begin
      r_readyEn <= 1'b1;
      if (w_push)      r_wrPtr <= r_wrPtr + 1'b1;
      if (w_grantLoad) r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_push, w_grantLoad})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_grantLoad || !w_qNotEmpty)
        r_starve <= '0;
      else if (w_grantIntu && (r_starve != c_STV_W'(STARVE_MAX)))
        r_starve <= r_starve + 1'b1;
    end
  end

  // Queue payload needs no reset: entries are only read once counted valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_qWarp[r_wrPtr] <= ldWarp_i;
      r_qMask[r_wrPtr] <= ldMask_i;
      r_qDest[r_wrPtr] <= ldDest_i;
      r_qData[r_wrPtr] <= ldData_i;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_held  <= 1'b0;
      r_hWarp <= '0;
      r_hMask <= '0;
      r_hDv   <= 1'b0;
      r_hDest <= '0;
      r_hData <= '0;
    end else if (w_intuLoad) begin
      r_held  <= 1'b1;
      r_hWarp <= intuWarp_i;
      r_hMask <= intuMask_i;
      r_hDv   <= intuDestValid_i;
      r_hDest <= intuDest_i;
      r_hData <= intuData_i;
    end else if (w_grantIntu) begin
      r_held  <= 1'b0;
    end
  end

  // Non-writing slots (idle or INTU without a destination) present all-zero fields.
  always_comb begin
    w_nValid = 1'b0;
    w_nWarp  = '0;
    w_nMask  = '0;
    w_nDest  = '0;
    w_nData  = '0;
    if (w_grantLoad) begin
      w_nValid = 1'b1;
      w_nWarp  = r_qWarp[r_rdPtr];
      w_nMask  = r_qMask[r_rdPtr];
      w_nDest  = r_qDest[r_rdPtr];
      w_nData  = r_qData[r_rdPtr];
    end else if (w_intuWrite) begin
      w_nValid = 1'b1;
      w_nWarp  = r_hWarp;
      w_nMask  = r_hMask;
      w_nDest  = r_hDest;
      w_nData  = r_hData;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wbValid_o    <= 1'b0;
      wbWarp_o     <= '0;
      wbMask_o     <= '0;
      wbDest_o     <= '0;
      wbData_o     <= '0;
      intuCommit_o <= 1'b0;
      loadCommit_o <= 1'b0;
    end else if (!stall_i) begin
      wbValid_o    <= w_nValid;
      wbWarp_o     <= w_nWarp;
      wbMask_o     <= w_nMask;
      wbDest_o     <= w_nDest;
      wbData_o     <= w_nData;
      intuCommit_o <= w_intuWrite;
      loadCommit_o <= w_grantLoad;
    end
  end

endmodule

`default_nettype wire
